// File: rtl/mem_stage_controller_if.sv
// Memory-stage bundle: EX/MEM control fields, data-memory port and pipeline feedback.
// The controller takes the master view; the pipeline/memory environment takes the slave view.
interface mem_stage_controller_if;
    logic        is_load;
    logic        is_store;
    logic [2:0]  load_variant;
    logic [2:0]  store_variant;
    logic [31:0] addr;
    logic [31:0] store_data;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] load_result;
    logic        load_valid;
    logic        pipe_stall;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        input  is_load, is_store, load_variant, store_variant, addr, store_data,
        input  mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output load_result, load_valid, pipe_stall, fault, fault_cause
    );

    modport slave (
        output is_load, is_store, load_variant, store_variant, addr, store_data,
        output mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  load_result, load_valid, pipe_stall, fault, fault_cause
    );
endinterface

// File: rtl/mem_stage_controller.sv
// RISC-V memory-stage sequencer: one req/ack transaction per load/store, byte-lane
// placement for stores, extraction/extension for loads, stall and fault reporting.
module mem_stage_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    mem_stage_controller_if.master bus
);

    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] load_result_q, load_result_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  lsb_q, lsb_d;
    logic [2:0]  variant_q, variant_d;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic [1:0]  size_sel;
    logic [31:0] wdata_new;
    logic [3:0]  be_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] extracted;
    logic        stall;

    // Access decode on the live EX/MEM fields; funct3[1:0] encodes the access size.
    always_comb begin
        access   = bus.is_load | bus.is_store;
        size_sel = bus.is_store ? bus.store_variant[1:0] : bus.load_variant[1:0];
        illegal  = 1'b0;
        if (bus.is_load && bus.is_store) begin
            illegal = 1'b1;
        end else if (bus.is_load) begin
            illegal = (bus.load_variant == 3'b011) || (bus.load_variant[2:1] == 2'b11);
        end else if (bus.is_store) begin
            illegal = (bus.store_variant == 3'b011) || bus.store_variant[2];
        end
        case (size_sel)
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = |bus.addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        wdata_new = '0;
        be_new    = '1;
        if (bus.is_store) begin
            case (bus.store_variant[1:0])
                2'b00: begin
                    wdata_new = {4{bus.store_data[7:0]}};
                    be_new    = 4'b0001 << bus.addr[1:0];
                end
                2'b01: begin
                    wdata_new = {2{bus.store_data[15:0]}};
                    be_new    = bus.addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_new = bus.store_data;
                    be_new    = '1;
                end
            endcase
        end
    end

    // Extraction uses the offset and variant captured at launch, not the live inputs.
    always_comb begin
        rd_byte = bus.mem_rdata[{lsb_q, 3'b000} +: 8];
        rd_half = bus.mem_rdata[{lsb_q[1], 4'b0000} +: 16];
        case (variant_q)
            3'b000:  extracted = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  extracted = {{16{rd_half[15]}}, rd_half};
            3'b100:  extracted = {24'h0, rd_byte};
            3'b101:  extracted = {16'h0, rd_half};
            default: extracted = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        load_result_d = load_result_q;
        load_valid_d  = 1'b0;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause_q;
        cnt_d         = cnt_q;
        lsb_d         = lsb_q;
        variant_d     = variant_q;
        stall         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (illegal || misaligned) begin
                        state_d       = S_FAULT;
                        fault_d       = 1'b1;
                        fault_cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.is_store;
                        mem_addr_d  = {bus.addr[31:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                        cnt_d       = '0;
                        lsb_d       = bus.addr[1:0];
                        variant_d   = bus.load_variant;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + CW'(1);
                // An acknowledge on the expiry cycle still completes the access.
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (!mem_we_q) begin
                        load_result_d = extracted;
                        load_valid_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                    state_d       = S_FAULT;
                end
            end
            S_DONE, S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            load_result_q <= '0;
            load_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            fault_cause_q <= '0;
            cnt_q         <= '0;
            lsb_q         <= '0;
            variant_q     <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            load_result_q <= load_result_d;
            load_valid_q  <= load_valid_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            cnt_q         <= cnt_d;
            lsb_q         <= lsb_d;
            variant_q     <= variant_d;
        end
    end

    // The stall is gated by reset so it drops with the asynchronous clear.
    assign bus.pipe_stall  = stall & ~reset;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.load_result = load_result_q;
    assign bus.load_valid  = load_valid_q;
    assign bus.fault       = fault_q;
    assign bus.fault_cause = fault_cause_q;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Randomized scoreboard bench for mem_stage_controller with a behavioural load/store model.
module tb_mem_stage_controller;

    localparam int unsigned TMO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_stage_controller_if bus();

    mem_stage_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        bit          is_fault;
        logic [1:0]  cause;
        logic [31:0] val;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_illegal(input bit l, input bit s, input logic [2:0] lv, input logic [2:0] sv);
        if (l && s) return 1'b1;
        if (l) return !(lv inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        return !(sv inside {3'b000, 3'b001, 3'b010});
    endfunction

    function automatic int ref_size(input bit s, input logic [2:0] lv, input logic [2:0] sv);
        logic [2:0] v;
        v = s ? sv : lv;
        case (v)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] lv, input logic [31:0] a, input logic [31:0] rd);
        int     size;
        int     base;
        longint v;
        size = ref_size(1'b0, lv, 3'b000);
        if (size == 4) return rd;
        base = int'(a % 4) - int'(a % 4) % size;
        v = (longint'(rd) >> (8 * base)) & ((longint'(1) << (8 * size)) - 1);
        if ((lv == 3'b000 || lv == 3'b001) && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return 32'(v);
    endfunction

    function automatic req_t ref_store(input logic [2:0] sv, input logic [31:0] a, input logic [31:0] sd);
        req_t r;
        int   size;
        int   base;
        size    = ref_size(1'b1, 3'b000, sv);
        base    = int'(a % 4);
        r.addr  = a & ~32'd3;
        r.we    = 1'b1;
        r.be    = '0;
        r.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            r.be[i]          = (i >= base) && (i < base + size);
            r.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    bit   req_prev = 1'b0;
    bit   have_cur = 1'b0;
    req_t cur;

    always @(negedge clock) begin
        if (reset) begin
            req_prev = 1'b0;
            have_cur = 1'b0;
        end else begin
            if (bus.mem_req) begin
                if (!req_prev) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 32'(bus.mem_req), 32'd0);
                        have_cur = 1'b0;
                    end else begin
                        cur      = req_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    check("req_addr",  bus.mem_addr,      cur.addr);
                    check("req_we",    32'(bus.mem_we),   32'(cur.we));
                    check("req_be",    32'(bus.mem_be),   32'(cur.be));
                    check("req_wdata", bus.mem_wdata,     cur.wdata);
                end
            end
            req_prev = bus.mem_req;
            if (bus.load_valid || bus.fault) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", {30'd0, bus.load_valid, bus.fault}, 32'd0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_kind_fault", {31'd0, bus.fault}, {31'd0, e.is_fault});
                    check("rsp_kind_load",  {31'd0, bus.load_valid}, {31'd0, !e.is_fault});
                    if (e.is_fault) check("fault_cause", 32'(bus.fault_cause), 32'(e.cause));
                    else            check("load_result", bus.load_result, e.val);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_acc(input bit l, input bit s, input logic [2:0] lv, input logic [2:0] sv,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input int dly, input bit stray);
        bit   acc;
        bit   ill;
        bit   mis;
        int   exp_stall;
        int   n;
        int   req_cycle;
        rsp_t r;
        req_t q;

        acc = l | s;
        ill = acc && ref_illegal(l, s, lv, sv);
        mis = acc && !ill && ((a % ref_size(s, lv, sv)) != 0);
        if (!acc)           exp_stall = 0;
        else if (ill || mis) exp_stall = 1;
        else if (dly < int'(TMO)) exp_stall = dly + 2;
        else                exp_stall = int'(TMO) + 1;

        if (ill || mis) begin
            r.is_fault = 1'b1; r.cause = ill ? 2'b10 : 2'b01; r.val = '0;
            rsp_q.push_back(r);
        end else if (acc) begin
            if (s) q = ref_store(sv, a, sd);
            else begin
                q.addr = a & ~32'd3; q.we = 1'b0; q.be = 4'b1111; q.wdata = '0;
            end
            req_q.push_back(q);
            if (dly >= int'(TMO)) begin
                r.is_fault = 1'b1; r.cause = 2'b11; r.val = '0;
                rsp_q.push_back(r);
            end else if (l) begin
                r.is_fault = 1'b0; r.cause = '0; r.val = ref_load(lv, a, rd);
                rsp_q.push_back(r);
            end
        end

        bus.is_load = l; bus.is_store = s; bus.load_variant = lv; bus.store_variant = sv;
        bus.addr = a; bus.store_data = sd;
        n = 0;
        req_cycle = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!bus.pipe_stall) break;
            n++;
            if (bus.mem_req) begin
                if (req_cycle == dly) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = rd;
                end
                req_cycle++;
            end
            @(posedge clock); #1;
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        // DONE/FAULT (or idle) cycle: inputs held, optional stray ack must be ignored.
        bus.mem_ack = stray;
        @(posedge clock); #1;
        bus.mem_ack = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.is_load = 1'b0; bus.is_store = 1'b0;
        bus.load_variant = '0; bus.store_variant = '0;
        bus.addr = '0; bus.store_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #3;
        check("rst_mem_req",     32'(bus.mem_req), 32'd0);
        check("rst_mem_we",      32'(bus.mem_we), 32'd0);
        check("rst_mem_addr",    bus.mem_addr, 32'd0);
        check("rst_mem_wdata",   bus.mem_wdata, 32'd0);
        check("rst_mem_be",      32'(bus.mem_be), 32'd0);
        check("rst_load_result", bus.load_result, 32'd0);
        check("rst_load_valid",  32'(bus.load_valid), 32'd0);
        check("rst_pipe_stall",  32'(bus.pipe_stall), 32'd0);
        check("rst_fault",       32'(bus.fault), 32'd0);
        check("rst_fault_cause", 32'(bus.fault_cause), 32'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        run_acc(1, 0, 3'b000, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0);
        run_acc(1, 0, 3'b100, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1);
        run_acc(0, 1, 3'b000, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 2, 0);
        run_acc(1, 0, 3'b010, 3'b000, 32'h3001, 32'h0, 32'h0, 0, 0);
        run_acc(1, 1, 3'b010, 3'b010, 32'h3000, 32'h0, 32'h0, 0, 0);
        run_acc(0, 1, 3'b000, 3'b010, 32'h4000, 32'hDEAD_BEEF, 32'h0, 9, 0);
        run_acc(0, 1, 3'b000, 3'b010, 32'h4004, 32'h1234_5678, 32'h0, int'(TMO) - 1, 0);
        run_acc(0, 0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 0, 1);
        run_acc(1, 0, 3'b101, 3'b000, 32'h5002, 32'h0, 32'hC3A5_7E11, 1, 0);
        run_acc(1, 0, 3'b001, 3'b000, 32'h5006, 32'h0, 32'hC3A5_7E11, 0, 0);

        // Asynchronous reset in the middle of a request.
        bus.is_load = 1'b1; bus.load_variant = 3'b010; bus.addr = 32'h100;
        req_q.push_back('{addr: 32'h100, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        @(posedge clock); #1;
        check("req_before_reset", 32'(bus.mem_req), 32'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("reset_drops_req",   32'(bus.mem_req), 32'd0);
        check("reset_drops_stall", 32'(bus.pipe_stall), 32'd0);
        idle_inputs();
        @(negedge clock); reset = 1'b0;
        req_q.delete();
        rsp_q.delete();
        @(posedge clock); #1;
        run_acc(1, 0, 3'b001, 3'b000, 32'h0, 32'h0, 32'h0000_8001, 0, 0);

        for (int i = 0; i < 80; i++) begin
            int unsigned k;
            bit          l;
            bit          s;
            logic [2:0]  lv;
            logic [2:0]  sv;
            logic [31:0] a;
            logic [2:0]  lset [5];
            lset = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            k  = $urandom_range(0, 9);
            l  = (k <= 4) || (k == 9);
            s  = (k >= 5 && k <= 7) || (k == 9);
            lv = ($urandom_range(0, 9) < 8) ? lset[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            sv = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[0] = 1'b0;
            if ($urandom_range(0, 2) != 0) a[1] = 1'b0;
            run_acc(l, s, lv, sv, a, $urandom, $urandom, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
